// File: rtl/async_fifo_rd_ctrl_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers (read and write side).
// Pointer width helper, Gray encoding and synchroniser depth limits live here.
package async_fifo_rd_ctrl_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_w(input int aw);
        return aw + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-side FIFO controller bus: incoming write pointer, pop request and all status outputs.
// The slave modport is the controller; the master modport is the consumer/testbench.
interface async_fifo_rd_ctrl_if
    import async_fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
);
    logic [ptr_w(ADDR_WIDTH)-1:0] wr_ptr_gray_i;
    logic                         rd_en_i;
    logic [ADDR_WIDTH-1:0]        rd_addr_o;
    logic [ptr_w(ADDR_WIDTH)-1:0] rd_ptr_gray_o;
    logic                         empty_o;
    logic                         almost_empty_o;
    logic [ptr_w(ADDR_WIDTH)-1:0] level_o;
    logic                         underflow_o;
    logic                         ptr_err_o;

    modport slave (
        input  wr_ptr_gray_i, rd_en_i,
        output rd_addr_o, rd_ptr_gray_o, empty_o, almost_empty_o,
               level_o, underflow_o, ptr_err_o
    );

    modport master (
        output wr_ptr_gray_i, rd_en_i,
        input  rd_addr_o, rd_ptr_gray_o, empty_o, almost_empty_o,
               level_o, underflow_o, ptr_err_o
    );
endinterface

// File: rtl/my_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module my_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);
    always_comb begin
        for (int i = 0; i < WIDTH; i++) bin_o[i] = ^(gray_i >> i);
    end
endmodule

// File: rtl/sync_ff_chain.sv
// Multi-flop clock-domain-crossing synchroniser; stage 0 is the only flop that sees the
// asynchronous input and no logic sits between stages.
module sync_ff_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

    // NOTE: the chain is a handful of real flops, not a RAM, so every stage gets the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the dual-clock FIFO: synchronises the write pointer,
// advances the read pointer on pops and registers empty/almost-empty/level/error flags.
module async_fifo_rd_ctrl
    import async_fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AEMPTY_THR  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    async_fifo_rd_ctrl_if.slave  bus
);
    localparam int PW    = ptr_w(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [PW-1:0] ptr_t;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("SYNC_STAGES out of range");
    end

    ptr_t wr_sync;
    ptr_t wr_bin;
    ptr_t rd_bin_q,  rd_bin_d;
    ptr_t rd_gray_q, rd_gray_d;
    ptr_t level_q,   level_d;
    logic empty_q,   empty_d;
    logic aempty_q,  aempty_d;
    logic ptr_err_q, ptr_err_d;
    logic pop;

    sync_ff_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.wr_ptr_gray_i),
        .q_o   (wr_sync)
    );

    my_gray2bin #(
        .WIDTH (PW)
    ) u_wr_g2b (
        .gray_i (wr_sync),
        .bin_o  (wr_bin)
    );

    // Flags are computed from the post-pop pointer so they are exact the cycle after a pop.
    // NOTE: every always_comb output is given a value before any branch, so no latch can form.
    always_comb begin
        pop       = bus.rd_en_i & ~empty_q;
        rd_bin_d  = rd_bin_q + ptr_t'(pop);
        rd_gray_d = ptr_t'(bin2gray(32'(rd_bin_d)));
        level_d   = wr_bin - rd_bin_d;
        empty_d   = (rd_gray_d == wr_sync);
        aempty_d  = (level_d <= ptr_t'(AEMPTY_THR));
        ptr_err_d = ptr_err_q | (level_d > ptr_t'(DEPTH));
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            ptr_err_q <= 1'b0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            aempty_q  <= aempty_d;
            ptr_err_q <= ptr_err_d;
        end
    end

    assign bus.rd_addr_o      = rd_bin_q[ADDR_WIDTH-1:0];
    assign bus.rd_ptr_gray_o  = rd_gray_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_empty_o = aempty_q;
    assign bus.level_o        = level_q;
    assign bus.underflow_o    = bus.rd_en_i & empty_q;
    assign bus.ptr_err_o      = ptr_err_q;
endmodule
